fpu_mul_arbiter: RTL and testbench

Shares one fpu_mul instance between NUM_REQ requesters using round-robin arbitration. Each requester presents an operand pair (a, b) with a single strobe. The block sequences the FPU's get_a/get_b/put_z handshakes and routes the product back to the requester that issued it. One operation is in flight at a time, matching the FPU's non-pipelined datapath.

---
 rtl/fpu_mul_arb_pkg.sv | 17 +
 rtl/fpu_mul_arbiter_rr_pick.sv | 26 ++
 rtl/fpu_mul_arbiter.sv | 164 ++++++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_arb_pkg.sv
// Shared types and constants for the fpu_mul round-robin arbiter.
package fpu_mul_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    WAIT_Z = 3'd4,
    RESP   = 3'd5
  } arb_state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int STATS_W     = 16;

endpackage

// File: rtl/fpu_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_vld
);

  always_comb begin
    int w_j;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_vld && i_req[w_j]) begin
        o_idx = IDX_W'(w_j);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Round-robin sharing of one non-pipelined fpu_mul among NUM_REQ requesters.
// Optional per-requester completion counters: define FPU_MUL_ARB_STATS_EN.
module fpu_mul_arbiter
  import fpu_mul_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  input  logic [NUM_REQ-1:0]       i_req_stb,
  output logic [NUM_REQ-1:0]       o_req_ack,
  output logic [WIDTH-1:0]         o_resp_z,
  output logic [NUM_REQ-1:0]       o_resp_stb,
  input  logic [NUM_REQ-1:0]       i_resp_ack,
  output logic [IDX_W-1:0]         o_resp_idx,
  output logic [WIDTH-1:0]         o_fpu_input_a,
  output logic                     o_fpu_input_a_stb,
  input  logic                     i_fpu_input_a_ack,
  output logic [WIDTH-1:0]         o_fpu_input_b,
  output logic                     o_fpu_input_b_stb,
  input  logic                     i_fpu_input_b_ack,
  input  logic [WIDTH-1:0]         i_fpu_output_z,
  input  logic                     i_fpu_output_z_stb,
  output logic                     o_fpu_output_z_ack
`ifdef FPU_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] o_grant_count
`endif
);

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [NUM_REQ-1:0] r_req_ack, w_req_ack_nxt;
  logic [NUM_REQ-1:0] r_resp_stb, w_resp_stb_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt, r_b, w_b_nxt, r_resp_z, w_resp_z_nxt;
  logic [IDX_W-1:0]   r_resp_idx, w_resp_idx_nxt;
  logic               r_a_stb, w_a_stb_nxt, r_b_stb, w_b_stb_nxt, r_z_ack, w_z_ack_nxt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_vld;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req (i_req_stb),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  // Every strobe/ack is computed one cycle ahead so the outputs come straight from flops.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_nxt       = r_rr_ptr;
    w_req_ack_nxt  = r_req_ack;
    w_resp_stb_nxt = r_resp_stb;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_resp_z_nxt   = r_resp_z;
    w_resp_idx_nxt = r_resp_idx;
    w_a_stb_nxt    = r_a_stb;
    w_b_stb_nxt    = r_b_stb;
    w_z_ack_nxt    = r_z_ack;
    case (r_state)
      IDLE: if (w_pick_vld) begin
        w_owner_nxt               = w_pick_idx;
        w_req_ack_nxt             = '0;
        w_req_ack_nxt[w_pick_idx] = 1'b1;
        w_state_nxt               = GRANT;
      end
      GRANT: if (i_req_stb[r_owner] && r_req_ack[r_owner]) begin
        w_a_nxt       = i_req_a[r_owner*WIDTH +: WIDTH];
        w_b_nxt       = i_req_b[r_owner*WIDTH +: WIDTH];
        w_req_ack_nxt = '0;
        w_a_stb_nxt   = 1'b1;
        w_state_nxt   = SEND_A;
      end
      SEND_A: if (r_a_stb && i_fpu_input_a_ack) begin
        w_a_stb_nxt = 1'b0;
        w_b_stb_nxt = 1'b1;
        w_state_nxt = SEND_B;
      end
      SEND_B: if (r_b_stb && i_fpu_input_b_ack) begin
        w_b_stb_nxt = 1'b0;
        w_z_ack_nxt = 1'b1;
        w_state_nxt = WAIT_Z;
      end
      WAIT_Z: if (r_z_ack && i_fpu_output_z_stb) begin
        w_z_ack_nxt             = 1'b0;
        w_resp_z_nxt            = i_fpu_output_z;
        w_resp_idx_nxt          = r_owner;
        w_resp_stb_nxt          = '0;
        w_resp_stb_nxt[r_owner] = 1'b1;
        w_state_nxt             = RESP;
      end
      RESP: if (r_resp_stb[r_owner] && i_resp_ack[r_owner]) begin
        w_resp_stb_nxt = '0;
        w_rr_nxt       = r_owner;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= IDX_W'(NUM_REQ-1);
      r_req_ack  <= '0;
      r_resp_stb <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_resp_z   <= '0;
      r_resp_idx <= '0;
      r_a_stb    <= 1'b0;
      r_b_stb    <= 1'b0;
      r_z_ack    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_req_ack  <= w_req_ack_nxt;
      r_resp_stb <= w_resp_stb_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_resp_z   <= w_resp_z_nxt;
      r_resp_idx <= w_resp_idx_nxt;
      r_a_stb    <= w_a_stb_nxt;
      r_b_stb    <= w_b_stb_nxt;
      r_z_ack    <= w_z_ack_nxt;
    end
  end

  assign o_req_ack          = r_req_ack;
  assign o_resp_stb         = r_resp_stb;
  assign o_resp_z           = r_resp_z;
  assign o_resp_idx         = r_resp_idx;
  assign o_fpu_input_a      = r_a;
  assign o_fpu_input_a_stb  = r_a_stb;
  assign o_fpu_input_b      = r_b;
  assign o_fpu_input_b_stb  = r_b_stb;
  assign o_fpu_output_z_ack = r_z_ack;

`ifdef FPU_MUL_ARB_STATS_EN
  logic [NUM_REQ-1:0][STATS_W-1:0] r_cnt;

  // Counts completed responses per requester, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == RESP && r_resp_stb[r_owner] && i_resp_ack[r_owner] &&
                 r_cnt[r_owner] != '1) begin
      r_cnt[r_owner] <= r_cnt[r_owner] + STATS_W'(1);
    end
  end

  assign o_grant_count = r_cnt;
`endif

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter: FPU stub, round-robin/product model, literal checks.
module tb_fpu_mul_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]   req_stb = '0, resp_ack = '0;
  logic [N-1:0]   req_ack, resp_stb;
  logic [W-1:0]   resp_z, fpu_a, fpu_b, fpu_z;
  logic [IW-1:0]  resp_idx;
  logic           fpu_a_stb, fpu_a_ack, fpu_b_stb, fpu_b_ack, fpu_z_stb, fpu_z_ack;
`ifdef FPU_MUL_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  fpu_mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .IDX_W(IW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_stb(req_stb), .o_req_ack(req_ack),
    .o_resp_z(resp_z), .o_resp_stb(resp_stb), .i_resp_ack(resp_ack), .o_resp_idx(resp_idx),
    .o_fpu_input_a(fpu_a), .o_fpu_input_a_stb(fpu_a_stb), .i_fpu_input_a_ack(fpu_a_ack),
    .o_fpu_input_b(fpu_b), .o_fpu_input_b_stb(fpu_b_stb), .i_fpu_input_b_ack(fpu_b_ack),
    .i_fpu_output_z(fpu_z), .i_fpu_output_z_stb(fpu_z_stb), .o_fpu_output_z_ack(fpu_z_ack)
`ifdef FPU_MUL_ARB_STATS_EN
    , .o_grant_count(grant_count)
`endif
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // IEEE single multiply for normal operands (exact cases), plus the FPU's special values.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s; logic [7:0] ea, eb; logic [47:0] p; int e;
    s = a[31] ^ b[31]; ea = a[30:23]; eb = b[30:23];
    if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0)) return 32'hFFC00000;
    if ((ea == 8'hFF && b[30:0] == 0) || (eb == 8'hFF && a[30:0] == 0)) return 32'hFFC00000;
    if (ea == 8'hFF || eb == 8'hFF) return {s, 8'hFF, 23'd0};
    if (ea == 0 || eb == 0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(ea) + int'(eb) - 127;
    if (p[47]) begin e++; return {s, e[7:0], p[46:24]}; end
    return {s, e[7:0], p[45:23]};
  endfunction

  // FPU stub: get_a, get_b, 4-cycle compute, put_z.
  int fst = 0, fcnt = 0;
  logic [W-1:0] fa = '0, fb = '0, fz = '0;
  assign fpu_a_ack = (fst == 0);
  assign fpu_b_ack = (fst == 1);
  assign fpu_z_stb = (fst == 3);
  assign fpu_z     = fz;
  always @(posedge clk) begin
    if (rst) fst <= 0;
    else case (fst)
      0: if (fpu_a_stb) begin fa <= fpu_a; fst <= 1; end
      1: if (fpu_b_stb) begin fb <= fpu_b; fst <= 2; fcnt <= 3; end
      2: if (fcnt == 0) begin fz <= fmul(fa, fb); fst <= 3; end else fcnt <= fcnt - 1;
      3: if (fpu_z_ack) fst <= 0;
      default: fst <= 0;
    endcase
  end

  function automatic int pick(input logic [N-1:0] pend, input int last);
    for (int k = 1; k <= N; k++) if (pend[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Model: who must win each arbitration, and what the owner's product must be.
  int m_last = N-1, own = 0;
  bit busy = 0;
  logic [31:0] m_z = '0;
  logic [N-1:0] prev_stb = '0, prev_ack = '0;
  int done_log[$];
  always @(negedge clk) begin
    if (rst) begin
      m_last = N-1; busy = 0; prev_ack = '0;
    end else begin
      if (req_ack != 0 && prev_ack == 0) begin
        own = pick(prev_stb, m_last);
        busy = 1;
        chk("grant", 32'(req_ack), (own < 0) ? 32'd0 : 32'(4'(1) << own));
        if (own < 0) own = 0;
        m_z = fmul(req_a[own*W +: W], req_b[own*W +: W]);
      end
      if (!busy) chk("no_resp_when_idle", 32'(resp_stb), 32'd0);
      else if (resp_stb != 0) begin
        chk("resp_onehot", 32'(resp_stb), 32'(4'(1) << own));
        chk("resp_idx", 32'(resp_idx), 32'(own));
        chk("resp_z", resp_z, m_z);
        if (resp_ack[own]) begin done_log.push_back(own); m_last = own; busy = 0; end
      end
      prev_ack = req_ack;
    end
    prev_stb = req_stb;
  end

  task automatic tick();
    logic [N-1:0] xr;
    @(posedge clk);
    xr = req_stb & req_ack;
    #1;
    req_stb = req_stb & ~xr;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_stb[i] = 1'b1;
  endtask

  task automatic get_resp(input int idx, input logic [31:0] z);
    int c = 0;
    while (resp_stb == 0 && c < 300) begin tick(); c++; end
    chk("lit_resp_stb", 32'(resp_stb), 32'(4'(1) << idx));
    chk("lit_resp_idx", 32'(resp_idx), 32'(idx));
    chk("lit_resp_z", resp_z, z);
    resp_ack = '1; tick(); resp_ack = '0;
  endtask

  initial begin
    int c;
    logic [31:0] held;
    repeat (2) tick();
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_resp_stb", 32'(resp_stb), 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_resp_idx", 32'(resp_idx), 0);
    chk("rst_fpu_hs", {29'd0, fpu_a_stb, fpu_b_stb, fpu_z_ack}, 0);
    rst = 1'b0;

    // single request: 2.0 * 3.0
    issue(0, 32'h40000000, 32'h40400000);
    get_resp(0, 32'h40C00000);

    // all four strobing out of reset: order 0,1,2,3
    rst = 1'b1; repeat (2) tick();
    for (int i = 0; i < N; i++) issue(i, 32'h3F800000, (i == 0) ? 32'h3F800000 :
                                      (i == 1) ? 32'h40000000 : (i == 2) ? 32'h40400000 : 32'h40800000);
    rst = 1'b0;
    done_log.delete();
    get_resp(0, 32'h3F800000);
    get_resp(1, 32'h40000000);
    get_resp(2, 32'h40400000);
    get_resp(3, 32'h40800000);
    chk("order_len", 32'(done_log.size()), 4);

    // round robin: 2 completes, then 1 and 3 together -> 3 first
    issue(2, 32'h40000000, 32'h40000000);
    get_resp(2, 32'h40800000);
    issue(1, 32'h3F800000, 32'h40400000);
    issue(3, 32'h40400000, 32'h40400000);
    get_resp(3, 32'h41100000);
    get_resp(1, 32'h40400000);

    // back-pressure: response held 20 cycles with requester 1 waiting
    issue(0, 32'h40A00000, 32'h40000000);
    c = 0;
    while (resp_stb == 0 && c < 300) begin tick(); c++; end
    held = resp_z;
    chk("bp_z", held, 32'h41200000);
    issue(1, 32'h3F800000, 32'h3F800000);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_stb", 32'(resp_stb), 32'h1);
      chk("bp_z_stable", resp_z, held);
      chk("bp_no_ack", 32'(req_ack), 0);
      chk("bp_fpu_idle", {30'd0, fst == 0, fpu_a_stb}, 32'h2);
    end
    get_resp(0, 32'h41200000);
    get_resp(1, 32'h3F800000);

    // inf * 0 -> NaN
    issue(2, 32'h7F800000, 32'h00000000);
    get_resp(2, 32'hFFC00000);

    // reset while waiting on the FPU result
    issue(0, 32'h40000000, 32'h40400000);
    c = 0;
    while (!fpu_z_ack && c < 300) begin tick(); c++; end
    chk("reached_wait_z", 32'(fpu_z_ack), 1);
    rst = 1'b1; tick();
    chk("mid_rst_hs", {25'd0, req_ack, fpu_a_stb, fpu_b_stb, fpu_z_ack}, 0);
    chk("mid_rst_resp", 32'(resp_stb), 0);
`ifdef FPU_MUL_ARB_STATS_EN
    chk("stats_cleared", grant_count[31:0] | grant_count[63:32] | grant_count[95:64] | grant_count[127:96], 0);
`endif
    rst = 1'b0;
    repeat (15) tick();
    chk("no_resp_after_rst", 32'(resp_stb), 0);
    issue(0, 32'h40000000, 32'h40400000);
    get_resp(0, 32'h40C00000);
`ifdef FPU_MUL_ARB_STATS_EN
    tick();
    chk("stats_r0", grant_count[15:0], 1);
    chk("stats_rest", grant_count[63:16], 0);
`endif
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
